// File: rtl/hazard_ctrl_if.sv
// Control/status bundle between the 5-stage datapath and the hazard control unit.
// The datapath drives through the master modport. The hazard unit uses the slave modport.
interface hazard_ctrl_if #(
    parameter int REGW = 5
);
    logic            halt;
    logic            ihit;
    logic            dhit;
    logic            dmemREN;
    logic            dmemWEN;
    logic            branch_taken;
    logic            jump;
    logic [REGW-1:0] ifid_rs;
    logic [REGW-1:0] ifid_rt;
    logic [REGW-1:0] idex_rs;
    logic [REGW-1:0] idex_rt;
    logic [REGW-1:0] idex_rd;
    logic            idex_memread;
    logic [REGW-1:0] xmem_rd;
    logic            xmem_regwen;
    logic [REGW-1:0] mwb_rd;
    logic            mwb_regwen;

    logic            stall_ifid;
    logic            stall_idex;
    logic            stall_xmem;
    logic            stall_wb;
    logic            flush_ifid;
    logic            flush_idex;
    logic            flush_xmem;
    logic            flush_wb;
    logic            pc_en;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            halted;
    logic            mem_timeout;

    modport master (
        output halt, ihit, dhit, dmemREN, dmemWEN, branch_taken, jump,
               ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, idex_memread,
               xmem_rd, xmem_regwen, mwb_rd, mwb_regwen,
        input  stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb,
               pc_en, fwd_a, fwd_b, halted, mem_timeout
    );

    modport slave (
        input  halt, ihit, dhit, dmemREN, dmemWEN, branch_taken, jump,
               ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, idex_memread,
               xmem_rd, xmem_regwen, mwb_rd, mwb_regwen,
        output stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb,
               pc_en, fwd_a, fwd_b, halted, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage core: registered RUN/MEMWAIT/LUSTALL/HALTED FSM,
// memory watchdog and EX-stage forwarding selects. Drives the latch stall/flush controls and pc_en.
module hazard_ctrl_unit #(
    parameter int REGW         = 5,
    parameter int LU_BUBBLES   = 1,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic          CLK,
    input  logic          nRST,
    hazard_ctrl_if.slave  hc
);
    typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_LUSTALL, ST_HALTED} state_t;

    localparam logic [2:0] LU_RELOAD = 3'(LU_BUBBLES - 1);
    localparam logic [7:0] WAIT_MAX  = 8'(MEM_WAIT_MAX);

    state_t     state_reg, state_next;
    logic [2:0] lu_cnt_reg, lu_cnt_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       mem_timeout_reg, mem_timeout_next;

    logic memop, mem_stall, redirect, lu;
    logic [7:0] wait_inc;
    // Bit order for both vectors: [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB.
    logic [3:0] stall_v, flush_v;
    logic       pc_en_v;

    assign memop     = hc.dmemREN | hc.dmemWEN;
    assign mem_stall = memop & ~hc.dhit;
    assign redirect  = hc.branch_taken | hc.jump;
    assign lu        = hc.idex_memread & (hc.idex_rd != '0) &
                       ((hc.idex_rd == hc.ifid_rs) | (hc.idex_rd == hc.ifid_rt));
    assign wait_inc  = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= ST_RUN;
            lu_cnt_reg      <= 3'd0;
            wait_cnt_reg    <= 8'd0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lu_cnt_reg      <= lu_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        lu_cnt_next      = lu_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        case (state_reg)
            ST_RUN: begin
                if (hc.halt) begin
                    state_next = ST_HALTED;
                end else if (mem_stall) begin
                    state_next    = ST_MEMWAIT;
                    wait_cnt_next = 8'd1;
                end else if (!redirect && lu && (LU_BUBBLES > 1)) begin
                    state_next  = ST_LUSTALL;
                    lu_cnt_next = LU_RELOAD;
                end
            end
            ST_MEMWAIT: begin
                if (!hc.dhit) begin
                    wait_cnt_next = wait_inc;
                end else begin
                    wait_cnt_next = 8'd0;
                    // A load-use stall interrupted by the wait resumes with its remaining bubbles.
                    if (hc.halt)
                        state_next = ST_HALTED;
                    else if (lu_cnt_reg != 3'd0)
                        state_next = ST_LUSTALL;
                    else
                        state_next = ST_RUN;
                end
            end
            ST_LUSTALL: begin
                if (mem_stall) begin
                    state_next    = ST_MEMWAIT;
                    wait_cnt_next = 8'd1;
                end else begin
                    lu_cnt_next = lu_cnt_reg - 3'd1;
                    if (lu_cnt_reg <= 3'd1)
                        state_next = ST_RUN;
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
        if (wait_cnt_next >= WAIT_MAX)
            mem_timeout_next = 1'b1;
    end

    always_comb begin
        stall_v = 4'b0000;
        flush_v = 4'b0000;
        pc_en_v = 1'b1;
        if (!nRST) begin
            flush_v = 4'b1111;
            pc_en_v = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (hc.halt) begin
                        stall_v = 4'b1000;
                        flush_v = 4'b0100;
                        pc_en_v = 1'b0;
                    end else begin
                        if (mem_stall) begin
                            stall_v = 4'b1110;
                            flush_v = 4'b0001;
                            pc_en_v = 1'b0;
                        end else if (redirect) begin
                            flush_v = 4'b1100;
                        end else if (lu) begin
                            stall_v = 4'b1000;
                            flush_v = 4'b0100;
                            pc_en_v = 1'b0;
                        end else if (!hc.ihit) begin
                            flush_v = 4'b1000;
                            pc_en_v = 1'b0;
                        end
                        // A completing data access shares the memory port, so the fetch is discarded.
                        if (memop && hc.dhit)
                            flush_v[3] = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    if (!hc.dhit) begin
                        stall_v = 4'b1110;
                        flush_v = 4'b0001;
                        pc_en_v = 1'b0;
                    end else begin
                        flush_v = redirect ? 4'b1100 : 4'b1000;
                    end
                end
                ST_LUSTALL: begin
                    if (mem_stall) begin
                        stall_v = 4'b1110;
                        flush_v = 4'b0001;
                    end else begin
                        stall_v = 4'b1000;
                        flush_v = 4'b0100;
                    end
                    pc_en_v = 1'b0;
                end
                ST_HALTED: begin
                    stall_v = 4'b1000;
                    flush_v = 4'b0100;
                    pc_en_v = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hc.stall_ifid  = stall_v[3];
    assign hc.stall_idex  = stall_v[2];
    assign hc.stall_xmem  = stall_v[1];
    assign hc.stall_wb    = stall_v[0];
    assign hc.flush_ifid  = flush_v[3];
    assign hc.flush_idex  = flush_v[2];
    assign hc.flush_xmem  = flush_v[1];
    assign hc.flush_wb    = flush_v[0];
    assign hc.pc_en       = pc_en_v;
    assign hc.halted      = (state_reg == ST_HALTED);
    assign hc.mem_timeout = mem_timeout_reg;

    // Operand 0 is ALU A (idex_rs), operand 1 is ALU B (idex_rt).
    logic [1:0][REGW-1:0] ex_src;
    logic [1:0][1:0]      fwd_sel;

    assign ex_src[0] = hc.idex_rs;
    assign ex_src[1] = hc.idex_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic xmem_hit, mwb_hit;
            assign xmem_hit = hc.xmem_regwen & (hc.xmem_rd != '0) & (hc.xmem_rd == ex_src[gi]);
            assign mwb_hit  = hc.mwb_regwen  & (hc.mwb_rd  != '0) & (hc.mwb_rd  == ex_src[gi]);
            assign fwd_sel[gi] = !nRST   ? 2'b00 :
                                 xmem_hit ? 2'b10 :
                                 mwb_hit  ? 2'b01 : 2'b00;
        end
    endgenerate

    assign hc.fwd_a = fwd_sel[0];
    assign hc.fwd_b = fwd_sel[1];
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: RUN-state priority table plus multi-cycle
// sequences (load-use bubbles, memory wait, watchdog, halt), compared through a scoreboard queue.
module tb_hazard_ctrl_unit;
    logic CLK;
    logic nRST;

    hazard_ctrl_if #(.REGW(5)) hc ();

    hazard_ctrl_unit #(.REGW(5), .LU_BUBBLES(2), .MEM_WAIT_MAX(15)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .hc  (hc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ctl bits: [6]halt [5]ihit [4]dhit [3]dmemREN [2]dmemWEN [1]branch_taken [0]jump
    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd;
        logic       memread;
        logic [4:0] xmem_rd;
        logic       xmem_wen;
        logic [4:0] mwb_rd;
        logic       mwb_wen;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_t;

    vec_t vecs[16];
    sb_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Output word: {stall ifid,idex,xmem,wb, flush ifid,idex,xmem,wb, pc_en, fwd_a, fwd_b, halted, mem_timeout}
    function automatic logic [14:0] o(input logic [3:0] st, input logic [3:0] fl, input logic pc,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic h, input logic t);
        return {st, fl, pc, fa, fb, h, t};
    endfunction

    function automatic vec_t mk(input string name, input logic [6:0] ctl,
                                input logic [4:0] ifid_rs, input logic [4:0] ifid_rt,
                                input logic [4:0] idex_rs, input logic [4:0] idex_rt,
                                input logic [4:0] idex_rd, input logic memread,
                                input logic [4:0] xmem_rd, input logic xmem_wen,
                                input logic [4:0] mwb_rd, input logic mwb_wen,
                                input logic [14:0] exp);
        vec_t v;
        v.name = name; v.ctl = ctl;
        v.ifid_rs = ifid_rs; v.ifid_rt = ifid_rt;
        v.idex_rs = idex_rs; v.idex_rt = idex_rt; v.idex_rd = idex_rd;
        v.memread = memread; v.xmem_rd = xmem_rd; v.xmem_wen = xmem_wen;
        v.mwb_rd = mwb_rd; v.mwb_wen = mwb_wen; v.exp = exp;
        return v;
    endfunction

    function automatic logic [14:0] actual();
        return {hc.stall_ifid, hc.stall_idex, hc.stall_xmem, hc.stall_wb,
                hc.flush_ifid, hc.flush_idex, hc.flush_xmem, hc.flush_wb,
                hc.pc_en, hc.fwd_a, hc.fwd_b, hc.halted, hc.mem_timeout};
    endfunction

    task automatic idle_inputs();
        hc.halt = 1'b0; hc.ihit = 1'b1; hc.dhit = 1'b1;
        hc.dmemREN = 1'b0; hc.dmemWEN = 1'b0; hc.branch_taken = 1'b0; hc.jump = 1'b0;
        hc.ifid_rs = '0; hc.ifid_rt = '0; hc.idex_rs = '0; hc.idex_rt = '0; hc.idex_rd = '0;
        hc.idex_memread = 1'b0; hc.xmem_rd = '0; hc.xmem_regwen = 1'b0;
        hc.mwb_rd = '0; hc.mwb_regwen = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        {hc.halt, hc.ihit, hc.dhit, hc.dmemREN, hc.dmemWEN, hc.branch_taken, hc.jump} = v.ctl;
        hc.ifid_rs = v.ifid_rs; hc.ifid_rt = v.ifid_rt;
        hc.idex_rs = v.idex_rs; hc.idex_rt = v.idex_rt; hc.idex_rd = v.idex_rd;
        hc.idex_memread = v.memread;
        hc.xmem_rd = v.xmem_rd; hc.xmem_regwen = v.xmem_wen;
        hc.mwb_rd = v.mwb_rd; hc.mwb_regwen = v.mwb_wen;
    endtask

    task automatic expect_out(input string name, input logic [14:0] exp);
        sb_t e;
        e.name = name; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        sb_t e;
        logic [14:0] a;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sb_q.pop_front();
            a = actual();
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s: got %b required %b", e.name, a, e.exp);
            end else begin
                $display("ok   %s: %b", e.name, a);
            end
        end
    endtask

    // Inputs must already be applied (just after a posedge); checks on the following negedge.
    task automatic check_neg(input string name, input logic [14:0] exp);
        expect_out(name, exp);
        @(negedge CLK);
        compare_out();
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Pulse the async reset between clock edges, comparing outputs while reset is held.
    task automatic reset_pulse(input string name, input logic do_check);
        nRST = 1'b0;
        #1;
        if (do_check) begin
            expect_out(name, o(4'b0000, 4'b1111, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
            compare_out();
        end
        #1;
        nRST = 1'b1;
    endtask

    localparam logic [14:0] IDLE   = 15'b0000_0000_1_00_00_0_0;
    localparam logic [14:0] LUST   = 15'b1000_0100_0_00_00_0_0;
    localparam logic [14:0] MWAIT  = 15'b1110_0001_0_00_00_0_0;
    localparam logic [14:0] REDIR  = 15'b0000_1100_1_00_00_0_0;
    localparam logic [14:0] DHITGO = 15'b0000_1000_1_00_00_0_0;

    initial begin
        vecs[0]  = mk("idle",             7'b0110000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        vecs[1]  = mk("halt_over_mem",    7'b1101000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUST);
        vecs[2]  = mk("load_miss",        7'b0101000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MWAIT);
        vecs[3]  = mk("mem_over_branch",  7'b0100110, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MWAIT);
        vecs[4]  = mk("branch_over_lu",   7'b0110010, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, REDIR);
        vecs[5]  = mk("jump",             7'b0110001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, REDIR);
        vecs[6]  = mk("lu_rs",            7'b0110000, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, LUST);
        vecs[7]  = mk("lu_r0_ignored",    7'b0110000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, IDLE);
        vecs[8]  = mk("lu_rt",            7'b0110000, 1, 7, 0, 0, 7, 1, 0, 0, 0, 0, LUST);
        vecs[9]  = mk("no_lu_not_load",   7'b0110000, 3, 0, 0, 0, 3, 0, 0, 0, 0, 0, IDLE);
        vecs[10] = mk("ihit_low",         7'b0010000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      o(4'b0000, 4'b1000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs[11] = mk("memhit_with_lu",   7'b0111000, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0,
                      o(4'b1000, 4'b1100, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        vecs[12] = mk("memhit_with_halt", 7'b1111000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUST);
        vecs[13] = mk("fwd_xmem_wins",    7'b0110000, 0, 0, 5, 0, 0, 0, 5, 1, 5, 1,
                      o(4'b0000, 4'b0000, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0));
        vecs[14] = mk("fwd_mwb_only",     7'b0110000, 0, 0, 5, 0, 0, 0, 5, 0, 5, 1,
                      o(4'b0000, 4'b0000, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0));
        vecs[15] = mk("fwd_split",        7'b0110000, 0, 0, 6, 9, 0, 0, 9, 1, 6, 1,
                      o(4'b0000, 4'b0000, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0));

        // Reset outputs must hold even with a halt and a forwarding match presented.
        idle_inputs();
        hc.halt = 1'b1; hc.xmem_rd = 5'd5; hc.xmem_regwen = 1'b1; hc.idex_rs = 5'd5;
        reset_pulse("reset_outputs", 1'b1);
        idle_inputs();

        // RUN-state priority table, each vector from a fresh reset.
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            reset_pulse("", 1'b0);
            next_cycle();
            drive(vecs[i]);
            check_neg(vecs[i].name, vecs[i].exp);
            idle_inputs();
        end

        // Load-use with two bubbles, then back to RUN.
        reset_pulse("", 1'b0);
        next_cycle();
        hc.idex_memread = 1'b1; hc.idex_rd = 5'd3; hc.ifid_rs = 5'd3;
        check_neg("lu_bubble1", LUST);
        next_cycle();
        check_neg("lu_bubble2", LUST);
        next_cycle();
        idle_inputs();
        check_neg("lu_back_to_run", IDLE);

        // Load waiting four cycles on dhit.
        reset_pulse("", 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            hc.dmemREN = 1'b1; hc.dhit = 1'b0;
            check_neg($sformatf("memwait_c%0d", k), MWAIT);
        end
        next_cycle();
        hc.dhit = 1'b1;
        check_neg("memwait_dhit", DHITGO);
        next_cycle();
        idle_inputs();
        check_neg("memwait_back_to_run", IDLE);

        // Watchdog: mem_timeout visible once wait_cnt has reached 15, sticky until reset.
        reset_pulse("", 1'b0);
        for (int k = 1; k <= 16; k++) begin
            next_cycle();
            hc.dmemWEN = 1'b1; hc.dhit = 1'b0;
            if (k >= 14)
                check_neg($sformatf("timeout_c%0d", k),
                          o(4'b1110, 4'b0001, 1'b0, 2'b00, 2'b00, 1'b0, k >= 16));
        end
        next_cycle();
        hc.dhit = 1'b1;
        check_neg("timeout_dhit", o(4'b0000, 4'b1000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1));
        next_cycle();
        idle_inputs();
        check_neg("timeout_sticky", o(4'b0000, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1));
        reset_pulse("timeout_cleared_by_reset", 1'b1);

        // Branch together with a load-use hazard: redirect only, no bubble afterwards.
        next_cycle();
        hc.branch_taken = 1'b1; hc.idex_memread = 1'b1; hc.idex_rd = 5'd3; hc.ifid_rs = 5'd3;
        check_neg("branch_lu", REDIR);
        next_cycle();
        idle_inputs();
        check_neg("branch_lu_no_lustall", IDLE);

        // Halt arriving during a memory wait, dhit two cycles later, branch on the dhit cycle.
        reset_pulse("", 1'b0);
        next_cycle();
        hc.dmemREN = 1'b1; hc.dhit = 1'b0;
        check_neg("halt_seq_entry", MWAIT);
        next_cycle();
        hc.halt = 1'b1;
        check_neg("halt_seq_wait1", MWAIT);
        next_cycle();
        check_neg("halt_seq_wait2", MWAIT);
        next_cycle();
        hc.dhit = 1'b1; hc.branch_taken = 1'b1;
        check_neg("halt_seq_dhit_branch", REDIR);
        next_cycle();
        idle_inputs();
        check_neg("halted", o(4'b1000, 4'b0100, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
        next_cycle();
        hc.dmemREN = 1'b1; hc.dhit = 1'b0;
        check_neg("halted_ignores_mem", o(4'b1000, 4'b0100, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
        idle_inputs();
        reset_pulse("halted_reset", 1'b1);
        next_cycle();
        check_neg("after_halt_reset_run", IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
